pv_sample_sequencer: RTL and testbench

Sequencer between the XADC AXI-Stream sample port and the HLS PV parameter estimator core. It captures one voltage sample (tid 0x10) and one current sample (tid 0x18) into a pair and optionally decimates the pair stream. It launches the estimator through its ap_ctrl_hs handshake, then registers the estimator's ap_return as a one-cycle result pulse. Capture runs continuously and is double-buffered against an in-flight estimation.

---
 rtl/pv_sample_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pv_sample_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pv_sample_sequencer.sv
// Pairs XADC voltage/current samples, decimates the pair stream and launches the
// HLS PV estimator via ap_ctrl_hs. Optional watchdog: define PV_SEQ_TIMEOUT_EN.
module pv_sample_sequencer #(
  parameter logic [4:0]  CH_V        = 5'h10,
  parameter logic [4:0]  CH_I        = 5'h18,
  parameter int unsigned DECIM       = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [15:0] s_tdata,
  input  logic [4:0]  s_tid,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic        est_start,
  input  logic        est_ready,
  input  logic        est_done,
  input  logic        est_idle,
  input  logic [31:0] est_return,
  output logic [15:0] est_v,
  output logic [15:0] est_i,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [15:0] pair_cnt,
  output logic [15:0] drop_cnt,
  output logic        busy,
  output logic        timeout_err
);

`ifdef PV_SEQ_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
`endif

  localparam logic [15:0] DEC_LAST = 16'(DECIM - 1);

  state_t      state, state_nxt;
  logic [15:0] v_hold, i_hold, pend_v, pend_i, dec_cnt;
  logic        v_flag, i_flag, pend_flag;
  logic        beat, beat_v, beat_i, pair_done, dec_hit, launch, finish;
  logic        orphan, pend_drop, tmo_hit;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign beat      = s_tvalid & s_tready;
  assign beat_v    = beat && (s_tid == CH_V);
  assign beat_i    = beat && (s_tid == CH_I);
  assign pair_done = v_flag & i_flag;
  assign dec_hit   = pair_done && (dec_cnt == DEC_LAST);
  assign launch    = (state == S_IDLE) && pend_flag && est_idle;
  assign finish    = ((state == S_START) && est_ready && est_done) ||
                     ((state == S_WAIT) && est_done);
  // A sample replacing one that is leaving in a completed pair is not an orphan.
  assign orphan    = ((beat_v && v_flag) || (beat_i && i_flag)) && !pair_done;
  assign pend_drop = dec_hit && pend_flag && !launch;
  assign busy      = (state != S_IDLE);

`ifdef PV_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_START || state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (state_nxt == S_ABORT) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    est_start = 1'b0;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_START;
      S_START: begin
        est_start = 1'b1;
        if (finish)         state_nxt = S_IDLE;
        else if (est_ready) state_nxt = S_WAIT;
`ifdef PV_SEQ_TIMEOUT_EN
        else if (tmo_hit)   state_nxt = S_ABORT;
`endif
      end
      S_WAIT: begin
        if (finish)       state_nxt = S_IDLE;
`ifdef PV_SEQ_TIMEOUT_EN
        else if (tmo_hit) state_nxt = S_ABORT;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= S_IDLE;
      s_tready     <= 1'b0;
      v_hold       <= '0;
      i_hold       <= '0;
      v_flag       <= 1'b0;
      i_flag       <= 1'b0;
      dec_cnt      <= '0;
      pend_flag    <= 1'b0;
      pend_v       <= '0;
      pend_i       <= '0;
      est_v        <= '0;
      est_i        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      pair_cnt     <= '0;
      drop_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      s_tready <= 1'b1;

      if (beat_v) begin
        v_hold <= s_tdata;
        v_flag <= 1'b1;
      end else if (pair_done) begin
        v_flag <= 1'b0;
      end
      if (beat_i) begin
        i_hold <= s_tdata;
        i_flag <= 1'b1;
      end else if (pair_done) begin
        i_flag <= 1'b0;
      end

      if (pair_done) dec_cnt <= dec_hit ? 16'd0 : dec_cnt + 16'd1;

      // Single pending slot: a launch and a new pending pair in one cycle keeps the slot full.
      if (dec_hit) begin
        pend_flag <= 1'b1;
        pend_v    <= v_hold;
        pend_i    <= i_hold;
      end else if (launch) begin
        pend_flag <= 1'b0;
      end

      if (launch) begin
        est_v <= pend_v;
        est_i <= pend_i;
      end

      result_valid <= finish;
      if (finish) result <= est_return;
      pair_cnt <= sat_add(pair_cnt, {1'b0, finish});
      drop_cnt <= sat_add(drop_cnt, {1'b0, orphan} + {1'b0, pend_drop});
    end
  end

endmodule

// File: tb/tb_pv_sample_sequencer.sv
// Scoreboard bench for pv_sample_sequencer: a DECIM=1 instance driven by a scripted
// estimator and a DECIM=4 instance with an instantly-completing estimator.
module tb_pv_sample_sequencer;
  localparam logic [4:0] CH_V = 5'h10;
  localparam logic [4:0] CH_I = 5'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_tdata;
  logic [4:0]  s_tid;
  logic        s_tvalid;
  logic        est_ready, est_done, est_idle;
  logic [31:0] est_return;

  logic        s_tready, est_start, result_valid, busy, timeout_err;
  logic [15:0] est_v, est_i, pair_cnt, drop_cnt;
  logic [31:0] result;

  logic        s_tready4, est_start4, result_valid4, busy4, timeout_err4;
  logic [15:0] est_v4, est_i4, pair_cnt4, drop_cnt4;
  logic [31:0] result4;

  always #5 clk = ~clk;

  pv_sample_sequencer #(.CH_V(CH_V), .CH_I(CH_I), .DECIM(1), .TIMEOUT_CYC(16)) dut (
    .ap_clk(clk), .ap_rst(rst), .s_tdata(s_tdata), .s_tid(s_tid), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .est_start(est_start), .est_ready(est_ready), .est_done(est_done),
    .est_idle(est_idle), .est_return(est_return), .est_v(est_v), .est_i(est_i),
    .result(result), .result_valid(result_valid), .pair_cnt(pair_cnt), .drop_cnt(drop_cnt),
    .busy(busy), .timeout_err(timeout_err));

  pv_sample_sequencer #(.CH_V(CH_V), .CH_I(CH_I), .DECIM(4), .TIMEOUT_CYC(16)) dut4 (
    .ap_clk(clk), .ap_rst(rst), .s_tdata(s_tdata), .s_tid(s_tid), .s_tvalid(s_tvalid),
    .s_tready(s_tready4), .est_start(est_start4), .est_ready(est_start4), .est_done(est_start4),
    .est_idle(1'b1), .est_return({est_v4, est_i4}), .est_v(est_v4), .est_i(est_i4),
    .result(result4), .result_valid(result_valid4), .pair_cnt(pair_cnt4), .drop_cnt(drop_cnt4),
    .busy(busy4), .timeout_err(timeout_err4));

  typedef struct {
    logic [15:0] v;
    logic [15:0] i;
    logic [31:0] ret;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic [31:0] r4_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rv_pulses = 0;
  int          exp_pairs = 0;

  always @(negedge clk) begin
    if (result_valid)  rv_pulses++;
    if (result_valid4) r4_q.push_back(result4);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] tid, input logic [15:0] d);
    s_tvalid = 1'b1;
    s_tid    = tid;
    s_tdata  = d;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] v, input logic [15:0] i, input logic [31:0] ret);
    send(CH_V, v);
    send(CH_I, i);
    exp_q.push_back('{v: v, i: i, ret: ret});
  endtask

  // Waits for est_start (bounded), checks latency and operands, then handshakes est_ready.
  task automatic launch_check(input int exp_lat);
    int lat = 0;
    while (!est_start && lat < 50) begin
      tick();
      lat++;
    end
    check("start_seen", {31'd0, est_start}, 32'd1);
    if (exp_lat >= 0) check("start_latency", lat, exp_lat);
    if (exp_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      cur = '{v: 16'hxxxx, i: 16'hxxxx, ret: 32'hxxxxxxxx};
    end else begin
      cur = exp_q.pop_front();
    end
    check("est_v", {16'd0, est_v}, {16'd0, cur.v});
    check("est_i", {16'd0, est_i}, {16'd0, cur.i});
    est_ready = 1'b1;
    tick();
    est_ready = 1'b0;
    check("start_drop", {31'd0, est_start}, 32'd0);
    check("busy_wait", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_check();
    est_return = cur.ret;
    est_done   = 1'b1;
    tick();
    est_done   = 1'b0;
    exp_pairs++;
    check("rv_high", {31'd0, result_valid}, 32'd1);
    check("result", result, cur.ret);
    check("pair_cnt", {16'd0, pair_cnt}, exp_pairs);
    tick();
    check("rv_low", {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses0;
    rst = 1'b1; s_tvalid = 1'b0; s_tid = '0; s_tdata = '0;
    est_ready = 1'b0; est_done = 1'b0; est_idle = 1'b1; est_return = '0;
    repeat (3) tick();
    check("rst_tready", {31'd0, s_tready}, 32'd0);
    check("rst_start", {31'd0, est_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pair", {16'd0, pair_cnt}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_est_vi", {est_v, est_i}, 32'd0);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    tick();
    check("tready_up", {31'd0, s_tready}, 32'd1);

    // Basic pair, estimator done 5 cycles after est_ready.
    send_pair(16'h0123, 16'h0456, 32'hDEADBEEF);
    launch_check(2);
    repeat (4) tick();
    check("hold_v", {16'd0, est_v}, 32'h0123);
    finish_check();
    check("rv_single", rv_pulses, 1);

    // Orphan voltage overwrite.
    send(CH_V, 16'h0001);
    send(CH_V, 16'h0002);
    send(CH_I, 16'h0003);
    exp_q.push_back('{v: 16'h0002, i: 16'h0003, ret: 32'h0000_1234});
    check("drop_orphan", {16'd0, drop_cnt}, 32'd1);
    launch_check(2);
    repeat (2) tick();
    finish_check();

    // Next pair captured while the estimator is busy.
    send_pair(16'h1111, 16'h2222, 32'hA5A5_0001);
    launch_check(2);
    send_pair(16'h3333, 16'h4444, 32'h5A5A_0002);
    tick();
    check("busy_est_v", {est_v, est_i}, 32'h1111_2222);
    repeat (3) tick();
    check("busy_est_v2", {est_v, est_i}, 32'h1111_2222);
    finish_check();
    launch_check(0);
    repeat (2) tick();
    finish_check();
    check("drop_after_busy", {16'd0, drop_cnt}, 32'd1);

    // Foreign tid beats are discarded.
    pulses0 = rv_pulses;
    repeat (3) send(5'h03, 16'hAAAA);
    repeat (3) tick();
    check("foreign_drop", {16'd0, drop_cnt}, 32'd1);
    check("foreign_pair", {16'd0, pair_cnt}, exp_pairs);
    check("foreign_busy", {31'd0, busy}, 32'd0);
    check("foreign_start", {31'd0, est_start}, 32'd0);

`ifdef PV_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      pulses0 = rv_pulses;
      send_pair(16'h7777, 16'h8888, 32'h0);
      launch_check(2);
      while (!timeout_err && n < 40) begin
        tick();
        n++;
      end
      check("tmo_set", {31'd0, timeout_err}, 32'd1);
      check("tmo_not_early", {31'd0, n >= 13}, 32'd1);
      tick();
      tick();
      check("tmo_idle", {31'd0, busy}, 32'd0);
      check("tmo_no_rv", rv_pulses, pulses0);
      check("tmo_pair", {16'd0, pair_cnt}, exp_pairs);
      check("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    end
`else
    check("tmo_tied", {31'd0, timeout_err}, 32'd0);
`endif

    // Reset while waiting for est_done.
    send_pair(16'h5555, 16'h6666, 32'h0);
    launch_check(2);
    rst = 1'b1;
    tick();
    check("rstw_start", {31'd0, est_start}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_pair", {16'd0, pair_cnt}, 32'd0);
    check("rstw_drop", {16'd0, drop_cnt}, 32'd0);
    check("rstw_tmo", {31'd0, timeout_err}, 32'd0);
    check("rstw_result", result, 32'd0);
    rst = 1'b0;
    exp_pairs = 0;
    tick();
    r4_q.delete();

    // Decimation by 4 over 8 back-to-back pairs.
    for (int k = 1; k <= 8; k++) begin
      send(CH_V, 16'h0100 + 16'(k));
      send(CH_I, 16'h0200 + 16'(k));
    end
    repeat (6) tick();
    check("dec_pair", {16'd0, pair_cnt4}, 32'd2);
    check("dec_drop", {16'd0, drop_cnt4}, 32'd0);
    check("dec_launches", r4_q.size(), 2);
    if (r4_q.size() == 2) begin
      check("dec_first", r4_q[0], 32'h0104_0204);
      check("dec_second", r4_q[1], 32'h0108_0208);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
